// File: rtl/pipe_pkg.sv
// Shared pipeline constants: RV32 opcode groups (inst[6:2]), the canonical NOP,
// the hazard FSM encoding and the register-use record produced by inst_use_decode.
package pipe_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [4:0] OP_OP     = 5'b01100;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  typedef struct packed {
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_written;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } use_t;

  // Only stores and branches have no destination register.
  function automatic logic op_writes_rd(input logic [4:0] op);
    case (op)
      OP_STORE, OP_BRANCH: return 1'b0;
      OP_LOAD, OP_OP, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/inst_use_decode.sv
// Register-use decode of one instruction word; shared by hazard detection and
// the forwarding network.
module inst_use_decode
  import pipe_pkg::*;
(
  input  logic [31:0] i_inst,
  output use_t        o_use
);

  logic [4:0] w_op;
  logic       w_unused_bits;

  assign w_op          = i_inst[6:2];
  assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12], i_inst[1:0]};

  always_comb begin
    o_use            = '0;
    o_use.rs1        = i_inst[19:15];
    o_use.rs2        = i_inst[24:20];
    o_use.rd         = i_inst[11:7];
    o_use.is_load    = (w_op == OP_LOAD);
    o_use.rs1_used   = !(w_op inside {OP_LUI, OP_AUIPC, OP_JAL});
    o_use.rs2_used   = (w_op inside {OP_OP, OP_STORE, OP_BRANCH});
    // x0 is never a real destination, so it can never cause a dependency.
    o_use.rd_written = op_writes_rd(w_op) && (i_inst[11:7] != 5'd0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, load-use bubbles and taken-branch
// flushes, with a debug FSM and saturating stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] inst_d,
  input  logic [31:0] inst_x,
  input  logic        br_taken_x,
  input  logic        dmem_req_m,
  input  logic        dmem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_x,
  output logic        stall_m,
  output logic        bubble_x,
  output logic        flush_d,
  output logic        flush_x,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [1:0]  state
);

  use_t        w_use_d;
  use_t        w_use_x;
  logic        w_mem_wait;
  logic        w_load_use;
  logic        w_br;
  logic        w_unused_dec;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_state;
  logic        r_br_pend;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  inst_use_decode u_dec_d (.i_inst(inst_d), .o_use(w_use_d));
  inst_use_decode u_dec_x (.i_inst(inst_x), .o_use(w_use_x));

  assign w_unused_dec = ^{w_use_d.rd, w_use_d.rd_written, w_use_d.is_load,
                          w_use_x.rs1, w_use_x.rs2, w_use_x.rs1_used, w_use_x.rs2_used};

  assign w_mem_wait = dmem_req_m & ~dmem_ready;
  assign w_load_use = w_use_x.is_load & w_use_x.rd_written &
                      ((w_use_d.rs1_used & (w_use_d.rs1 == w_use_x.rd)) |
                       (w_use_d.rs2_used & (w_use_d.rs2 == w_use_x.rd)));
  // A branch seen during a memory wait stays frozen in X and is flushed once the wait ends.
  assign w_br       = br_taken_x | r_br_pend;

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_x  = 1'b0;
    stall_m  = 1'b0;
    bubble_x = 1'b0;
    flush_d  = 1'b0;
    flush_x  = 1'b0;
    if (reset_n) begin
      if (w_mem_wait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_x = 1'b1;
        stall_m = 1'b1;
      end else if (w_load_use) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_x = 1'b1;
      end else if (w_br) begin
        flush_d = 1'b1;
        flush_x = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait)      w_state_nxt = ST_MEM_WAIT;
        else if (w_load_use) w_state_nxt = ST_LU_STALL;
        else if (w_br)       w_state_nxt = ST_FLUSH;
        else                 w_state_nxt = ST_RUN;
      end
      ST_MEM_WAIT: w_state_nxt = dmem_ready ? ST_RUN : ST_MEM_WAIT;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_br_pend   <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= sat_inc(r_stall_cnt, stall_f);
      r_flush_cnt <= sat_inc(r_flush_cnt, flush_d);
      if (w_mem_wait && br_taken_x) r_br_pend <= 1'b1;
      else if (!w_mem_wait)         r_br_pend <= 1'b0;
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares outputs, state and counters.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] inst_d = NOP;
  logic [31:0] inst_x = NOP;
  logic        br_taken_x = 1'b0;
  logic        dmem_req_m = 1'b0;
  logic        dmem_ready = 1'b1;
  logic        stall_f, stall_d, stall_x, stall_m, bubble_x, flush_d, flush_x;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state;

  hazard_ctrl dut (
    .clock(clock), .reset_n(reset_n), .inst_d(inst_d), .inst_x(inst_x),
    .br_taken_x(br_taken_x), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x), .stall_m(stall_m),
    .bubble_x(bubble_x), .flush_d(flush_d), .flush_x(flush_x),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clock = ~clock;

  // flag order: {stall_f, stall_d, stall_x, stall_m, bubble_x, flush_d, flush_x}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] ST4  = 7'b1111000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] FL   = 7'b0000011;

  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] LW2  = 32'h0000A103;
  localparam logic [31:0] ADD  = 32'h00228333;
  localparam logic [31:0] LUI5 = 32'h000282B7;

  typedef struct {
    int          id;
    logic [6:0]  fl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   vid    = 0;

  task automatic check(input string nm, input int id, input logic [15:0] got, input logic [15:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL v%0d %s got %h expected %h", id, nm, got, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("flags", e.id,
              {9'd0, stall_f, stall_d, stall_x, stall_m, bubble_x, flush_d, flush_x},
              {9'd0, e.fl});
        check("state", e.id, {14'd0, state}, {14'd0, e.st});
        check("stall_cnt", e.id, stall_cnt, e.sc);
        check("flush_cnt", e.id, flush_cnt, e.fc);
      end
    end
  end

  task automatic drive(input logic rst, input logic [31:0] ix, input logic [31:0] id,
                       input logic br, input logic req, input logic rdy);
    @(posedge clock);
    #1;
    reset_n    = rst;
    inst_x     = ix;
    inst_d     = id;
    br_taken_x = br;
    dmem_req_m = req;
    dmem_ready = rdy;
  endtask

  task automatic step(input logic rst, input logic [31:0] ix, input logic [31:0] id,
                      input logic br, input logic req, input logic rdy,
                      input logic [6:0] fl, input logic [1:0] st,
                      input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    drive(rst, ix, id, br, req, rdy);
    e.id = vid; e.fl = fl; e.st = st; e.sc = sc; e.fc = fc;
    q.push_back(e);
    vid++;
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int w;
    // reset dominates any hazard inputs
    step(0, LW5, ADD, 1, 1, 0, NONE, ST_RUN, 0, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN, 0, 0);
    // load-use on rs1
    step(1, LW5, ADD, 0, 0, 1, LU,   ST_RUN,      0, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_LU_STALL, 1, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,      1, 0);
    // rd = x0 never hazards
    step(1, LW0, ADD, 0, 0, 1, NONE, ST_RUN, 1, 0);
    // load-use on rs2
    step(1, LW2, ADD, 0, 0, 1, LU,   ST_RUN,      1, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_LU_STALL, 2, 0);
    // LUI does not read rs1
    step(1, LW5, LUI5, 0, 0, 1, NONE, ST_RUN, 2, 0);
    // memory wait for 3 cycles
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_RUN,      2, 0);
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_MEM_WAIT, 3, 0);
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_MEM_WAIT, 4, 0);
    step(1, NOP, NOP, 0, 1, 1, NONE, ST_MEM_WAIT, 5, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,      5, 0);
    // taken branch in RUN
    step(1, NOP, NOP, 1, 0, 1, FL,   ST_RUN,   5, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_FLUSH, 5, 1);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,   5, 1);
    // taken branch held through a memory wait, flushed on first ready cycle
    step(1, NOP, NOP, 1, 1, 0, ST4,  ST_RUN,      5, 1);
    step(1, NOP, NOP, 1, 1, 0, ST4,  ST_MEM_WAIT, 6, 1);
    step(1, NOP, NOP, 0, 1, 1, FL,   ST_MEM_WAIT, 7, 1);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,      7, 2);
    // memory wait outranks load-use
    step(1, LW5, ADD, 0, 1, 0, ST4,  ST_RUN,      7, 2);
    step(1, LW5, ADD, 0, 1, 1, LU,   ST_MEM_WAIT, 8, 2);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,      9, 2);
    // asynchronous reset mid memory wait
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_RUN,      9,  2);
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_MEM_WAIT, 10, 2);
    step(0, NOP, NOP, 0, 1, 0, NONE, ST_RUN,      0,  0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,      0,  0);
    // stall counter saturation
    step(1, NOP, NOP, 0, 1, 0, ST4, ST_RUN, 0, 0);
    for (int i = 0; i < 65535; i++) drive(1, NOP, NOP, 0, 1, 0);
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_MEM_WAIT, 16'hFFFF, 0);
    step(1, NOP, NOP, 0, 1, 0, ST4,  ST_MEM_WAIT, 16'hFFFF, 0);
    step(1, NOP, NOP, 0, 1, 1, NONE, ST_MEM_WAIT, 16'hFFFF, 0);
    step(1, NOP, NOP, 0, 0, 1, NONE, ST_RUN,      16'hFFFF, 0);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(negedge clock);
      #1;
      w++;
    end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
